// File: rtl/full_adder.sv
// Ripple-carry full adder cell (WIDTH bits), the leaf of the adder/subtractor chains.
// OUT_REG=1 adds a single result register with synchronous active-high reset.
module full_adder #(
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0]   carry_p0;
    logic [WIDTH-1:0] sum_p0;

    assign carry_p0[0] = cin;

    // Stage p0: combinational ripple chain, one carry stage per bit
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign sum_p0[i]     = a[i] ^ b[i] ^ carry_p0[i];
        assign carry_p0[i+1] = (a[i] & b[i]) | (a[i] & carry_p0[i]) | (b[i] & carry_p0[i]);
    end

    if (OUT_REG != 0) begin : g_reg
        logic [WIDTH-1:0] sum_p1;
        logic             cout_p1;

        // Stage p1: registered result; reset discards the value captured at that edge
        always_ff @(posedge clk) begin
            if (rst) begin
                sum_p1  <= '0;
                cout_p1 <= 1'b0;
            end else begin
                sum_p1  <= sum_p0;
                cout_p1 <= carry_p0[WIDTH];
            end
        end

        assign sum  = sum_p1;
        assign cout = cout_p1;
    end else begin : g_comb
        // Clock and reset have no role in the purely combinational cell
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;

        assign sum  = sum_p0;
        assign cout = carry_p0[WIDTH];
    end

endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder: truth table, subtractor chain, wide adds,
// registered latency/reset behaviour and a scoreboarded random regression.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [0:0]  a1 = '0, b1 = '0;
    logic        ci1 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        ci8 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ci16 = 1'b0;

    logic [0:0]  s1c, s1r;
    logic        co1c, co1r;
    logic [7:0]  s8c, s8r;
    logic        co8c, co8r;
    logic [15:0] s16c, s16r;
    logic        co16c, co16r;

    full_adder #(.WIDTH(1), .OUT_REG(0)) u1c (.clk(clk), .rst(rst), .a(a1), .b(b1), .cin(ci1), .sum(s1c), .cout(co1c));
    full_adder #(.WIDTH(1), .OUT_REG(1)) u1r (.clk(clk), .rst(rst), .a(a1), .b(b1), .cin(ci1), .sum(s1r), .cout(co1r));
    full_adder #(.WIDTH(8), .OUT_REG(0)) u8c (.clk(clk), .rst(rst), .a(a8), .b(b8), .cin(ci8), .sum(s8c), .cout(co8c));
    full_adder #(.WIDTH(8), .OUT_REG(1)) u8r (.clk(clk), .rst(rst), .a(a8), .b(b8), .cin(ci8), .sum(s8r), .cout(co8r));
    full_adder #(.WIDTH(16), .OUT_REG(0)) u16c (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(ci16), .sum(s16c), .cout(co16c));
    full_adder #(.WIDTH(16), .OUT_REG(1)) u16r (.clk(clk), .rst(rst), .a(a16), .b(b16), .cin(ci16), .sum(s16r), .cout(co16r));

    // 8-bit subtractor built from eight 1-bit cells
    logic [7:0] sa = '0, sb = '0;
    logic [7:0] sbn;
    logic [7:0] sd;
    logic [8:0] sc;

    assign sbn   = ~sb;
    assign sc[0] = 1'b1;

    for (genvar g = 0; g < 8; g++) begin : g_sub
        full_adder #(.WIDTH(1), .OUT_REG(0)) u_cell (
            .clk(clk), .rst(rst),
            .a(sa[g]), .b(sbn[g]), .cin(sc[g]),
            .sum(sd[g]), .cout(sc[g+1])
        );
    end

    int n_vec = 0;
    int n_err = 0;

    logic [1:0]  q1[$];
    logic [8:0]  q8[$];
    logic [16:0] q16[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  v;
        logic [1:0]  e1;
        logic [8:0]  e8;
        logic [16:0] e16;
        logic [7:0]  ta[3], tb[3];
        logic        tc[3];
        logic [8:0]  te[3];

        // Exhaustive 1-bit truth table: {cout,sum} is the count of ones
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            a1 = v[2]; b1 = v[1]; ci1 = v[0];
            #1;
            e1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
            chk($sformatf("tt%0d", i), {62'd0, co1c, s1c}, {62'd0, e1});
        end

        // Subtractor chain
        sa = 8'd130; sb = 8'd123; #1;
        chk("sub_130_123", {55'd0, sc[8], sd}, {55'd0, 1'b1, 8'd7});
        sa = 8'd123; sb = 8'd130; #1;
        chk("sub_123_130", {55'd0, sc[8], sd}, {55'd0, 1'b0, 8'd249});

        // Wide combinational boundary cases
        ta = '{8'd255, 8'd200, 8'd0};
        tb = '{8'd1,   8'd55,  8'd0};
        tc = '{1'b0,   1'b1,   1'b0};
        te = '{9'h100, 9'h100, 9'h000};
        for (int i = 0; i < 3; i++) begin
            a8 = ta[i]; b8 = tb[i]; ci8 = tc[i];
            #1;
            chk($sformatf("w8c_%0d", i), {55'd0, co8c, s8c}, {55'd0, te[i]});
        end

        // Reset held for two edges
        rst = 1'b1;
        tick();
        tick();
        chk("rst_w1",  {62'd0, co1r, s1r},   64'd0);
        chk("rst_w8",  {55'd0, co8r, s8r},   64'd0);
        chk("rst_w16", {47'd0, co16r, s16r}, 64'd0);

        // One-cycle latency after reset release
        rst = 1'b0; a8 = 8'd100; b8 = 8'd27; ci8 = 1'b1;
        #1;
        chk("lat_before", {55'd0, co8r, s8r}, 64'd0);
        tick();
        chk("lat_after", {55'd0, co8r, s8r}, {55'd0, 9'd128});

        // Reset asserted mid-stream on the edge carrying i=5
        for (int i = 1; i <= 10; i++) begin
            a8 = 8'(i); b8 = 8'(i); ci8 = 1'b0;
            rst = (i == 5);
            q8.push_back((i == 5) ? 9'd0 : 9'(2 * i));
            tick();
            chk($sformatf("mid_%0d", i), {55'd0, co8r, s8r}, {55'd0, q8.pop_front()});
        end
        rst = 1'b0;

        // Random regression over all configurations
        for (int n = 0; n < 10000; n++) begin
            a1 = 1'($urandom); b1 = 1'($urandom); ci1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            a16 = 16'($urandom); b16 = 16'($urandom); ci16 = 1'($urandom);
            e1  = 2'(a1) + 2'(b1) + 2'(ci1);
            e8  = 9'(a8) + 9'(b8) + 9'(ci8);
            e16 = 17'(a16) + 17'(b16) + 17'(ci16);
            q1.push_back(e1);
            q8.push_back(e8);
            q16.push_back(e16);
            #1;
            chk("rnd_w1c",  {62'd0, co1c, s1c},   {62'd0, e1});
            chk("rnd_w8c",  {55'd0, co8c, s8c},   {55'd0, e8});
            chk("rnd_w16c", {47'd0, co16c, s16c}, {47'd0, e16});
            tick();
            chk("rnd_w1r",  {62'd0, co1r, s1r},   {62'd0, q1.pop_front()});
            chk("rnd_w8r",  {55'd0, co8r, s8r},   {55'd0, q8.pop_front()});
            chk("rnd_w16r", {47'd0, co16r, s16r}, {47'd0, q16.pop_front()});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
